// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the fetch stage
// (instruction reads) and the memory stage (data reads and writes).
// One access is issued per cycle. The read data is routed back to the stage
// that issued the read one cycle later.
//
// Build option: define MEM_ARB_STARVE_EN to add the fetch starvation guard.
// With the guard, fetch wins over data once it has been denied STARVE_LIMIT
// cycles in a row. Without it, data always has priority.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   if_req/if_addr      fetch read request, held until if_ready
//   if_ready            fetch granted this cycle (combinational)
//   if_valid/if_rdata   fetch read data, one cycle after the grant
//   stall_f             fetch request present but not granted
//   dm_req/we/addr/wdata data request, held until dm_ready
//   dm_ready            data granted this cycle (combinational)
//   dm_valid/dm_rdata   data read data, one cycle after a read grant
//   mem_addr/we/wdata   memory request for the granted access
//   mem_rdata           memory read data, one cycle after the address
module mem_port_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          stall_f,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // The state records which access was issued in the previous cycle. That
  // access is the one whose data now sits on mem_rdata.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    DM_RD = 2'd2,
    DM_WR = 2'd3
  } state_t;

  localparam logic [2:0] STARVE_LIMIT_W = 3'(STARVE_LIMIT);

  state_t state_r;
  state_t state_next_s;
  logic   if_grant_s;
  logic   dm_grant_s;
  logic   force_if_s;

`ifdef MEM_ARB_STARVE_EN
  logic [2:0] starve_cnt_r;

  // Count consecutive denied fetch cycles; any grant or an idle fetch restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 3'd0;
    end else if (!if_req || if_grant_s) begin
      starve_cnt_r <= 3'd0;
    end else if (starve_cnt_r != 3'd7) begin
      starve_cnt_r <= starve_cnt_r + 3'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign force_if_s = if_req && (starve_cnt_r == STARVE_LIMIT_W);
`else
  // The limit only has an effect when the starvation guard is built in.
  assign force_if_s = (STARVE_LIMIT_W == 3'd0) & 1'b0;
`endif

  // Grant selection: data has priority unless fetch is forced to win.
  always_comb begin
    if_grant_s = 1'b0;
    dm_grant_s = 1'b0;
    if (force_if_s) begin
      if_grant_s = 1'b1;
    end else if (dm_req) begin
      dm_grant_s = 1'b1;
    end else if (if_req) begin
      if_grant_s = 1'b1;
    end else begin
      if_grant_s = 1'b0;
      dm_grant_s = 1'b0;
    end
  end

  assign if_ready = if_grant_s;
  assign dm_ready = dm_grant_s;
  assign stall_f  = if_req & ~if_grant_s;

  // Memory request: drive the granted requester's access; an idle port drives zeros.
  always_comb begin
    mem_addr  = {AW{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = {DW{1'b0}};
    if (dm_grant_s) begin
      mem_addr  = dm_addr;
      mem_we    = dm_we;
      mem_wdata = dm_wdata;
    end else if (if_grant_s) begin
      mem_addr  = if_addr;
    end else begin
      mem_addr  = {AW{1'b0}};
    end
  end

  // Response state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state depends only on this cycle's grant, so every state can go to any state.
  always_comb begin
    state_next_s = IDLE;
    if (if_grant_s) begin
      state_next_s = IF_RD;
    end else if (dm_grant_s && !dm_we) begin
      state_next_s = DM_RD;
    end else if (dm_grant_s && dm_we) begin
      state_next_s = DM_WR;
    end else begin
      state_next_s = IDLE;
    end
  end

  // Read-data routing. Reset gates the valids so that a read pending when
  // reset arrives is discarded.
  always_comb begin
    if_valid = 1'b0;
    if_rdata = {DW{1'b0}};
    dm_valid = 1'b0;
    dm_rdata = {DW{1'b0}};
    if (rst) begin
      if_valid = 1'b0;
      dm_valid = 1'b0;
    end else begin
      case (state_r)
        IF_RD: begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end
        DM_RD: begin
          dm_valid = 1'b1;
          dm_rdata = mem_rdata;
        end
        DM_WR: begin
          dm_valid = 1'b0;
        end
        IDLE: begin
          if_valid = 1'b0;
        end
        default: begin
          if_valid = 1'b0;
          dm_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic.
// The expected response of every cycle comes from a behavioural model. The
// model keeps its own copy of memory and a record of which read is
// outstanding.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          stall_f;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ready;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_rdata(if_rdata), .stall_f(stall_f),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory attached to the arbiter.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            pend_if, pend_dm;
  logic [DW-1:0] pend_if_d, pend_dm_d;
  int            deny_cnt;
  bit            g_if, g_dm;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model in the middle of the cycle.
  task automatic check_cycle();
    bit force_f, e_ifv, e_dmv;
    logic [AW-1:0] e_addr;
    #3;
    force_f = STARVE_EN && if_req && (deny_cnt == STARVE_LIMIT);
    g_dm = dm_req && !force_f;
    g_if = if_req && (force_f || !dm_req);
    e_addr = g_dm ? dm_addr : (g_if ? if_addr : '0);
    e_ifv = pend_if && !rst;
    e_dmv = pend_dm && !rst;
    chk("if_ready", 32'(if_ready), 32'(g_if));
    chk("dm_ready", 32'(dm_ready), 32'(g_dm));
    chk("stall_f", 32'(stall_f), 32'(if_req && !g_if));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_we", 32'(mem_we), 32'(g_dm && dm_we));
    chk("mem_wdata", 32'(mem_wdata), 32'(g_dm ? dm_wdata : 16'h0000));
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("if_rdata", 32'(if_rdata), 32'(e_ifv ? pend_if_d : 16'h0000));
    chk("dm_valid", 32'(dm_valid), 32'(e_dmv));
    chk("dm_rdata", 32'(dm_rdata), 32'(e_dmv ? pend_dm_d : 16'h0000));
  endtask

  // Clock edge, then commit the access the model decided on.
  task automatic advance();
    @(posedge clk);
    #1;
    if (rst) begin
      pend_if = 1'b0;
      pend_dm = 1'b0;
      deny_cnt = 0;
    end else begin
      pend_if = g_if;
      pend_if_d = ref_mem[if_addr];
      pend_dm = g_dm && !dm_we;
      pend_dm_d = ref_mem[dm_addr];
      if (g_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
      deny_cnt = (if_req && !g_if) ? deny_cnt + 1 : 0;
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[12'h010] = 16'hA5C3; ref_mem[12'h010] = 16'hA5C3;
    mem[12'h100] = 16'h1234; ref_mem[12'h100] = 16'h1234;
    mem[12'h020] = 16'h0F0F; ref_mem[12'h020] = 16'h0F0F;
    pend_if = 1'b0; pend_dm = 1'b0; deny_cnt = 0;
    pend_if_d = '0; pend_dm_d = '0;
    idle_inputs();
    rst = 1'b1;
    #1;
    // Reset with no requests: everything quiet.
    for (int i = 0; i < 2; i++) begin
      check_cycle(); advance();
    end
    rst = 1'b0;
    check_cycle(); advance();

    // Fetch only.
    if_req = 1'b1; if_addr = 12'h010;
    check_cycle();
    chk("fo_ready", 32'(if_ready), 32'd1);
    chk("fo_stall", 32'(stall_f), 32'd0);
    advance();
    if_req = 1'b0;
    check_cycle();
    chk("fo_valid", 32'(if_valid), 32'd1);
    chk("fo_data", 32'(if_rdata), 32'h0000A5C3);
    advance();

    // Fetch and data read in conflict: data wins, fetch follows.
    if_req = 1'b1; if_addr = 12'h020;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h100;
    check_cycle();
    chk("cf_dm_ready", 32'(dm_ready), 32'd1);
    chk("cf_stall", 32'(stall_f), 32'd1);
    advance();
    dm_req = 1'b0;
    check_cycle();
    chk("cf_dm_valid", 32'(dm_valid), 32'd1);
    chk("cf_dm_data", 32'(dm_rdata), 32'h00001234);
    chk("cf_if_ready", 32'(if_ready), 32'd1);
    advance();
    if_req = 1'b0;
    check_cycle();
    chk("cf_if_data", 32'(if_rdata), 32'h00000F0F);
    advance();

    // Write, then fetch of the same address returns the new word.
    if_req = 1'b1; if_addr = 12'h030;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h030; dm_wdata = 16'hBEEF;
    check_cycle();
    chk("wf_mem_we", 32'(mem_we), 32'd1);
    advance();
    dm_req = 1'b0; dm_we = 1'b0;
    check_cycle();
    chk("wf_no_dm_valid", 32'(dm_valid), 32'd0);
    chk("wf_if_ready", 32'(if_ready), 32'd1);
    advance();
    if_req = 1'b0;
    check_cycle();
    chk("wf_data", 32'(if_rdata), 32'h0000BEEF);
    advance();

    // Back-to-back alternating fetch and data reads.
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      if (i % 2 == 0) begin
        if_req = 1'b1; if_addr = 12'(i);
      end else begin
        dm_req = 1'b1; dm_addr = 12'(12'h100 + i);
      end
      check_cycle(); advance();
    end
    idle_inputs();
    check_cycle(); advance();

    // Reset the cycle after a data read grant discards the data.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h100;
    check_cycle(); advance();
    dm_req = 1'b0; rst = 1'b1;
    check_cycle();
    chk("rm_dm_valid", 32'(dm_valid), 32'd0);
    chk("rm_if_valid", 32'(if_valid), 32'd0);
    chk("rm_mem_we", 32'(mem_we), 32'd0);
    advance();
    rst = 1'b0;
    check_cycle();
    chk("rm_after_dm_valid", 32'(dm_valid), 32'd0);
    advance();

    // Starvation: both requesters held high.
    if_req = 1'b1; if_addr = 12'h040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h101;
    for (int i = 0; i < 8; i++) begin
      check_cycle();
      chk("starve_if_ready", 32'(if_ready), 32'(STARVE_EN && i == 4));
      advance();
    end
    idle_inputs();
    check_cycle(); advance();

    // Random traffic on a small address window, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(49) == 0);
      if_req = $urandom_range(1);
      if_addr = 12'($urandom_range(15));
      dm_req = $urandom_range(1);
      dm_we = $urandom_range(1);
      dm_addr = 12'($urandom_range(15));
      dm_wdata = 16'($urandom);
      check_cycle(); advance();
    end
    rst = 1'b0;
    idle_inputs();
    check_cycle(); advance();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
